// File: rtl/gpu_raster_pkg.sv
// Shared raster-back-end definitions.
//   fb_state_t    : frame-buffer writer sequencing states
//   pix_ofs_w()   : width of a linear pixel offset (0 .. x_res*y_res-1)
package gpu_raster_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_t;

  // A one-pixel screen still needs a one-bit offset register.
  localparam int PIX_OFS_W_MIN = 1;

  function automatic int pix_ofs_w(input int x_res, input int y_res);
    return (x_res * y_res > 1) ? $clog2(x_res * y_res) : PIX_OFS_W_MIN;
  endfunction

endpackage

// File: rtl/fb_fifo.sv
// Synchronous fragment FIFO, first-word-fall-through head.
//   clk, rst          : clock, async active-high reset (pointers only)
//   push, push_data   : write port (ignored when full)
//   pop               : advance head (ignored when empty)
//   head              : current head entry
//   full, empty       : occupancy flags
module fb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fb_writer.sv
// Colour frame-buffer writer: turns depth-passed fragments into memory writes
// and performs full-screen colour clears.
//   clk_i, rst_i            : clock, async active-high reset
//   frag_*_i, depth_pass_i  : fragment stream from the depth test
//   frag_ready_o            : fragment accept
//   fb_base_address_i       : colour-buffer base word address
//   clear_i, clear_color_i  : clear request and clear value
//   mem_w_valid_o/ready_i   : write-port handshake; mem_addr_o, mem_data_o payload
//   clear_done_o, busy_o    : clear completion pulse, activity flag
//
// state    | meaning
// ST_RUN   | accept fragments, write them out of the FIFO
// ST_DRAIN | clear pending: stop accepting, flush queued fragments
// ST_CLEAR | sweep every pixel with the latched clear colour
// ST_DONE  | one-cycle completion pulse, then back to ST_RUN
module fb_writer
  import gpu_raster_pkg::*;
#(
  parameter int X_RES      = 1280,
  parameter int Y_RES      = 720,
  parameter int ADDR_SIZE  = 32,
  parameter int COLOR_SIZE = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     frag_valid_i,
  output logic                     frag_ready_o,
  input  logic [$clog2(X_RES)-1:0] frag_x_i,
  input  logic [$clog2(Y_RES)-1:0] frag_y_i,
  input  logic [COLOR_SIZE-1:0]    frag_color_i,
  input  logic                     depth_pass_i,
  input  logic [ADDR_SIZE-1:0]     fb_base_address_i,
  input  logic                     clear_i,
  input  logic [COLOR_SIZE-1:0]    clear_color_i,
  output logic                     mem_w_valid_o,
  input  logic                     mem_w_ready_i,
  output logic [ADDR_SIZE-1:0]     mem_addr_o,
  output logic [COLOR_SIZE-1:0]    mem_data_o,
  output logic                     clear_done_o,
  output logic                     busy_o
);

  localparam int CNT_W = pix_ofs_w(X_RES, Y_RES);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(X_RES * Y_RES - 1);
  localparam int ENTRY_W = ADDR_SIZE + COLOR_SIZE;

  fb_state_t              state;
  logic [CNT_W-1:0]       pix_cnt;
  logic [COLOR_SIZE-1:0]  clr_color;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_W-1:0]     fifo_head;
  logic [ADDR_SIZE-1:0]   frag_addr;
  logic                   push;
  logic                   pop;
  logic                   draining;
  logic                   wr_fire;

  assign frag_addr = fb_base_address_i
                   + ADDR_SIZE'(frag_y_i) * ADDR_SIZE'(X_RES)
                   + ADDR_SIZE'(frag_x_i);

  // Readiness depends on full only, so a same-cycle pop never frees a slot
  // early. Held low while reset is asserted.
  assign frag_ready_o = !rst_i && (state == ST_RUN) && !fifo_full;
  assign push         = frag_valid_i && frag_ready_o && depth_pass_i;

  assign draining      = (state == ST_RUN) || (state == ST_DRAIN);
  assign mem_w_valid_o = (draining && !fifo_empty) || (state == ST_CLEAR);
  assign wr_fire       = mem_w_valid_o && mem_w_ready_i;
  assign pop           = wr_fire && draining;

  assign clear_done_o = (state == ST_DONE);
  assign busy_o       = !((state == ST_RUN) && fifo_empty);

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    if (state == ST_CLEAR) begin
      mem_addr_o = fb_base_address_i + ADDR_SIZE'(pix_cnt);
      mem_data_o = clr_color;
    end else if (mem_w_valid_o) begin
      mem_addr_o = fifo_head[ENTRY_W-1 -: ADDR_SIZE];
      mem_data_o = fifo_head[COLOR_SIZE-1:0];
    end
  end

  fb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data ({frag_addr, frag_color_i}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_RUN;
      pix_cnt   <= '0;
      clr_color <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (clear_i) begin
            clr_color <= clear_color_i;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (wr_fire) begin
            if (pix_cnt == LAST_PIX) begin
              pix_cnt <= '0;
              state   <= ST_DONE;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
module tb_fb_writer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    logic [10:0] x;
    logic [9:0]  y;
    logic [31:0] color;
    logic        pass;
    logic        exp_ready;
    logic        exp_busy;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        frag_valid = 1'b0;
  logic        depth_pass = 1'b0;
  logic        clear = 1'b0;
  logic        mem_ready = 1'b1;
  logic [10:0] fx = '0;
  logic [9:0]  fy = '0;
  logic [31:0] color = '0;
  logic [31:0] base = 32'h1000;
  logic [31:0] clear_color = '0;

  logic        a_ready, a_valid, a_done, a_busy;
  logic [31:0] a_addr, a_data;
  logic        b_ready, b_valid, b_done, b_busy;
  logic [31:0] b_addr, b_data;

  wire         o_frag_ready = sel ? b_ready : a_ready;
  wire         o_mem_valid  = sel ? b_valid : a_valid;
  wire         o_clear_done = sel ? b_done  : a_done;
  wire         o_busy       = sel ? b_busy  : a_busy;
  wire  [31:0] o_mem_addr   = sel ? b_addr  : a_addr;
  wire  [31:0] o_mem_data   = sel ? b_data  : a_data;

  int errors = 0;
  int checks = 0;
  wr_t exp_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  fb_writer dut_a (
    .clk_i             (clk),
    .rst_i             (rst),
    .frag_valid_i      (frag_valid & ~sel),
    .frag_ready_o      (a_ready),
    .frag_x_i          (fx),
    .frag_y_i          (fy),
    .frag_color_i      (color),
    .depth_pass_i      (depth_pass),
    .fb_base_address_i (base),
    .clear_i           (clear & ~sel),
    .clear_color_i     (clear_color),
    .mem_w_valid_o     (a_valid),
    .mem_w_ready_i     (mem_ready),
    .mem_addr_o        (a_addr),
    .mem_data_o        (a_data),
    .clear_done_o      (a_done),
    .busy_o            (a_busy)
  );

  fb_writer #(.X_RES(4), .Y_RES(2)) dut_b (
    .clk_i             (clk),
    .rst_i             (rst),
    .frag_valid_i      (frag_valid & sel),
    .frag_ready_o      (b_ready),
    .frag_x_i          (fx[1:0]),
    .frag_y_i          (fy[0]),
    .frag_color_i      (color),
    .depth_pass_i      (depth_pass),
    .fb_base_address_i (base),
    .clear_i           (clear & sel),
    .clear_color_i     (clear_color),
    .mem_w_valid_o     (b_valid),
    .mem_w_ready_i     (mem_ready),
    .mem_addr_o        (b_addr),
    .mem_data_o        (b_data),
    .clear_done_o      (b_done),
    .busy_o            (b_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed write must match the oldest expectation,
  // and a stalled write must hold its payload.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  wr_t         w;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", o_mem_valid, 1'b1);
        check("hold_addr", o_mem_addr, prev_addr);
        check("hold_data", o_mem_data, prev_data);
      end
      if (o_mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("wr_extra", o_mem_valid, 1'b0);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", o_mem_addr, w.addr);
          check("wr_data", o_mem_data, w.data);
        end
      end
      stall_prev = o_mem_valid && !mem_ready;
      prev_addr  = o_mem_addr;
      prev_data  = o_mem_data;
    end
  end

  task automatic send(input logic [31:0] b, input logic [10:0] x, input logic [9:0] y,
                      input logic [31:0] c, input logic p, input logic cl,
                      input logic [31:0] ea, output logic acc);
    @(posedge clk); #1;
    base = b; fx = x; fy = y; color = c; depth_pass = p; clear = cl; frag_valid = 1'b1;
    @(negedge clk);
    acc = o_frag_ready;
    @(posedge clk); #1;
    frag_valid = 1'b0;
    clear = 1'b0;
    if (acc && p) exp_q.push_back('{addr: ea, data: c});
  endtask

  task automatic drain_wait(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, o_frag_ready, 1'b0);
    check({tag, "_valid"}, o_mem_valid, 1'b0);
    check({tag, "_done"},  o_clear_done, 1'b0);
    check({tag, "_busy"},  o_busy, 1'b0);
    check({tag, "_addr"},  o_mem_addr, 32'h0);
    check({tag, "_data"},  o_mem_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   pulses;
    int   quiet;
    logic found;

    vecs[0] = '{32'h1000,     11'd3,    10'd2,   32'hFF00FF00, 1'b1, 1'b1, 1'b1, 32'h00001A03};
    vecs[1] = '{32'h1000,     11'd0,    10'd0,   32'h11111111, 1'b1, 1'b1, 1'b1, 32'h00001000};
    vecs[2] = '{32'h1000,     11'd5,    10'd5,   32'h55555555, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{32'h1000,     11'd1279, 10'd719, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'h000E1FFF};
    vecs[4] = '{32'h1000,     11'd100,  10'd200, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 32'h0003F864};
    vecs[5] = '{32'hFFFFFFFF, 11'd1,    10'd0,   32'h0BADF00D, 1'b1, 1'b1, 1'b1, 32'h00000000};

    // Reset values
    #3;
    check_zero_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", o_frag_ready, 1'b1);

    // Single fragments, memory always ready
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].base, vecs[i].x, vecs[i].y, vecs[i].color, vecs[i].pass, 1'b0,
           vecs[i].exp_addr, acc);
      check("vec_ready", acc, vecs[i].exp_ready);
      check("vec_busy", o_busy, vecs[i].exp_busy);
      check("vec_valid", o_mem_valid, vecs[i].exp_busy);
      if (vecs[i].pass) begin
        check("vec_port_addr", o_mem_addr, vecs[i].exp_addr);
        check("vec_port_data", o_mem_data, vecs[i].color);
      end
    end
    drain_wait("vec_drain", 20);

    // Back-pressure: four entries fit, the fifth is refused
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(32'h1000, 11'(k), 10'(k), 32'hB0000000 + 32'(k), 1'b1, 1'b0,
           32'h1000 + 32'(k) * 32'd1280 + 32'(k), acc);
      check("bp_ready", acc, (k < 4) ? 1'b1 : 1'b0);
    end
    check("bp_head_addr", o_mem_addr, 32'h1000);
    check("bp_busy", o_busy, 1'b1);
    @(posedge clk); #1 mem_ready = 1'b1;
    drain_wait("bp_drain", 30);
    check("bp_idle_busy", o_busy, 1'b0);

    // Small screen: fragments queued, clear requested with the last one
    @(posedge clk); #1;
    sel = 1'b1; base = 32'h200; mem_ready = 1'b0; clear_color = 32'h0;
    send(32'h200, 11'd1, 10'd1, 32'hAAAA0001, 1'b1, 1'b0, 32'h205, acc);
    check("clr_frag0_ready", acc, 1'b1);
    send(32'h200, 11'd2, 10'd0, 32'hAAAA0002, 1'b1, 1'b1, 32'h202, acc);
    check("clr_frag1_ready", acc, 1'b1);
    for (int k = 0; k < 8; k++) exp_q.push_back('{addr: 32'h200 + 32'(k), data: 32'h0});
    @(negedge clk);
    check("drain_ready", o_frag_ready, 1'b0);
    check("drain_busy", o_busy, 1'b1);

    pulses = 0;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 4; i++) begin
      @(posedge clk); #1;
      mem_ready = (i < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
      clear = (i == 2);
      if (i == 2) clear_color = 32'hFFFFFFFF;
      @(negedge clk);
      if (o_clear_done) pulses++;
      if (exp_q.size() == 0) quiet++;
    end
    @(posedge clk); #1 clear = 1'b0;
    check("clr_queue_empty", exp_q.size(), 0);
    check("clr_done_pulses", pulses, 1);
    @(negedge clk);
    check("clr_after_ready", o_frag_ready, 1'b1);
    check("clr_after_busy", o_busy, 1'b0);

    // Reset in the middle of a sweep
    mem_ready = 1'b1;
    clear_color = 32'h12345678;
    for (int k = 0; k < 3; k++) exp_q.push_back('{addr: 32'h200 + 32'(k), data: 32'h12345678});
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_mem_valid && o_mem_addr == 32'h203) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("sweep_reached_3", found, 1'b1);
    rst = 1'b1;
    #1;
    check_zero_outputs("mid_rst");
    check("mid_rst_queue", exp_q.size(), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release_ready", o_frag_ready, 1'b1);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_clear_done) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    check("mid_rst_no_write", o_mem_valid, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter X_RES, default 1280, horizontal resolution in pixels.
REQ-002 Parameter Y_RES, default 720, vertical resolution in pixels.
REQ-003 Parameter ADDR_SIZE, default 32, memory word-address width.
REQ-004 Parameter COLOR_SIZE, default 32, RGBA pixel width.
REQ-005 Parameter FIFO_DEPTH, default 4, power of two, fragment buffer entries.
REQ-006 One clock and one reset: reset is asynchronous and active-high.
REQ-007 clk_i  in  1  clock; all state changes on its rising edge.
REQ-008 rst_i  in  1  asynchronous active-high reset.
REQ-009 frag_valid_i  in  1  fragment from depth-test stage is valid.
REQ-010 frag_ready_o  out  1  fragment accepted when valid and ready are both high at an edge.
REQ-011 frag_x_i  in  $clog2(X_RES)  pixel x.
REQ-012 frag_y_i  in  $clog2(Y_RES)  pixel y.
REQ-013 frag_color_i  in  COLOR_SIZE  shaded colour.
REQ-014 depth_pass_i  in  1  depth result; 0 means consume and drop.
REQ-015 fb_base_address_i  in  ADDR_SIZE  colour-buffer base word address.
REQ-016 clear_i  in  1  single-cycle glClear(GL_COLOR_BUFFER_BIT) request.
REQ-017 clear_color_i  in  COLOR_SIZE  clear value, sampled with clear_i.
REQ-018 mem_w_valid_o / mem_w_ready_i  out/in  1  write-port handshake.
REQ-019 mem_addr_o  out  ADDR_SIZE; mem_data_o  out  COLOR_SIZE  write address and data.
REQ-020 clear_done_o  out  1  one-cycle pulse at clear completion; busy_o  out  1  high unless RUN with an empty FIFO.

Function
REQ-021 Address = fb_base_address_i + frag_y_i*X_RES + frag_x_i, computed at acceptance, stored in FIFO with colour; modulo 2^ADDR_SIZE.
REQ-022 States: RUN, DRAIN, CLEAR, DONE.
REQ-023 RUN: frag_ready_o = !fifo_full; accepted fragments with depth_pass_i=1 pushed; depth_pass_i=0 consumed, not pushed.
REQ-024 Full FIFO: frag_ready_o=0 even if a pop occurs the same cycle (no bypass).
REQ-025 mem_w_valid_o = !fifo_empty in RUN/DRAIN; address/data come from FIFO head; a pushed fragment is visible at the port one edge after acceptance.
REQ-026 mem_w_valid_o, mem_addr_o, mem_data_o held stable until mem_w_ready_i; pop only on handshake.
REQ-027 clear_i in RUN: latch clear_color_i, go to DRAIN; a fragment accepted at the same edge is still written before the sweep.
REQ-028 DRAIN: frag_ready_o=0; to CLEAR when the FIFO is empty.
REQ-029 CLEAR: frag_ready_o=0; pixel counter 0..X_RES*Y_RES-1; mem_addr_o = base + counter, data = latched colour; counter increments per handshake.
REQ-030 Handshake at counter X_RES*Y_RES-1 -> DONE; DONE asserts clear_done_o for one cycle, then RUN with counter 0.
REQ-031 clear_i outside RUN ignored.
REQ-032 Writes issued strictly in acceptance order; no fragment dropped when depth_pass_i=1.

Reset
REQ-033 rst_i asserted at any time, including mid-sweep: state RUN, FIFO empty, counter 0, latched colour 0.
REQ-034 During reset: frag_ready_o=0, mem_w_valid_o=0, clear_done_o=0, busy_o=0, mem_addr_o=0, mem_data_o=0.
REQ-035 frag_ready_o rises the first cycle after rst_i deasserts.

Structure
REQ-036 fb_state_t enum and the pixel-offset width constant live in shared package gpu_raster_pkg.
REQ-037 FIFO is a sub-module fb_fifo (synchronous, FIFO_DEPTH entries, full/empty flags).

Verification
REQ-038 Base 0x1000, fragment (x=3,y=2,colour 0xFF00FF00, pass=1), ready=1 -> one write addr 0x1A03, data 0xFF00FF00, one edge later.
REQ-039 Fragment with pass=0 -> accepted, no write, busy_o stays 0.
REQ-040 mem_w_ready_i=0, push 5 fragments -> 4 accepted, frag_ready_o=0 on the 5th; release -> 4 writes in order.
REQ-041 X_RES=4, Y_RES=2, 2 queued fragments, clear_i colour 0x0 -> 2 fragment writes, then 8 writes addr base..base+7, clear_done_o pulses once.
REQ-042 rst_i asserted at sweep counter 3 -> outputs zero immediately; after release RUN, frag_ready_o=1, no further clear writes.
